// File: rtl/enigma_multi_rotor.sv
// rtl/enigma_multi_rotor.sv - multi-rotor substitution cipher with serial table load and odometer stepping
// Forward and inverse tables are written together so decrypt walks the chain backwards in one cycle.
module enigma_multi_rotor #(
    parameter int SYM_W   = 6,
    parameter int NUM_ROT = 2,
    parameter int ROT_W   = 2
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             load,
    input  logic [ROT_W-1:0] load_rot,
    input  logic [SYM_W-1:0] load_idx,
    input  logic [SYM_W-1:0] code_in,
    input  logic             in_valid,
    input  logic             encrypt,
    input  logic             crypt_mode,
    output logic [SYM_W-1:0] code_out,
    output logic             code_valid,
    output logic             ready
);
    localparam int DEPTH = 2 ** SYM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYM_W-1:0] tbl [NUM_ROT][DEPTH];
    logic [SYM_W-1:0] inv [NUM_ROT][DEPTH];
    logic [SYM_W-1:0] off      [NUM_ROT];
    logic [SYM_W-1:0] off_next [NUM_ROT];
    logic [SYM_W-1:0] enc_val, enc_idx, dec_val;
    logic             accept, carry;

    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load)  state_next = LOAD;
            LOAD:    if (!load) state_next = READY;
            READY:   if (load)  state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    assign ready  = (state == READY);
    assign accept = ready && in_valid && !load;

    // Rotor selects with no matching table fall through every compare and are dropped.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROT; r++) begin
            if (load && load_rot == ROT_W'(r)) begin
                tbl[r][load_idx] <= code_in;
                inv[r][code_in]  <= load_idx;
            end
        end
    end

    always_comb begin
        enc_idx = '0;
        enc_val = code_in;
        for (int r = 0; r < NUM_ROT; r++) begin
            enc_idx = enc_val + off[r];
            enc_val = tbl[r][enc_idx];
        end
    end

    always_comb begin
        dec_val = code_in;
        for (int r = NUM_ROT - 1; r >= 0; r--) begin
            dec_val = inv[r][dec_val] - off[r];
        end
    end

    // Odometer: each rotor advances only when every lower rotor wraps this step.
    always_comb begin
        carry = 1'b1;
        for (int r = 0; r < NUM_ROT; r++) begin
            off_next[r] = off[r];
            if (carry) begin
                off_next[r] = off[r] + SYM_W'(1);
                carry       = (off[r] == SYM_W'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            for (int r = 0; r < NUM_ROT; r++) off[r] <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= accept;
            if (accept) code_out <= encrypt ? enc_val : dec_val;
            if (load) begin
                for (int r = 0; r < NUM_ROT; r++) off[r] <= '0;
            end else if (accept && crypt_mode) begin
                for (int r = 0; r < NUM_ROT; r++) off[r] <= off_next[r];
            end
        end
    end
endmodule

// File: tb/tb_enigma_multi_rotor.sv
// tb/tb_enigma_multi_rotor.sv - scoreboard bench for enigma_multi_rotor against an arithmetic rotor model
module tb_enigma_multi_rotor;
    localparam int SYM_W   = 6;
    localparam int NUM_ROT = 2;
    localparam int ROT_W   = 2;
    localparam int DEPTH   = 64;

    logic             clk = 1'b0;
    logic             srstn;
    logic             load;
    logic [ROT_W-1:0] load_rot;
    logic [SYM_W-1:0] load_idx;
    logic [SYM_W-1:0] code_in;
    logic             in_valid;
    logic             encrypt;
    logic             crypt_mode;
    logic [SYM_W-1:0] code_out;
    logic             code_valid;
    logic             ready;

    int tt    [NUM_ROT][DEPTH];
    int inv_t [NUM_ROT][DEPTH];
    int pos;
    int span;
    int checks = 0;
    int errors = 0;
    int exp_q [$];
    int pt [23];
    int ct [23];

    enigma_multi_rotor #(.SYM_W(SYM_W), .NUM_ROT(NUM_ROT), .ROT_W(ROT_W)) dut (
        .clk(clk), .srstn(srstn), .load(load), .load_rot(load_rot), .load_idx(load_idx),
        .code_in(code_in), .in_valid(in_valid), .encrypt(encrypt), .crypt_mode(crypt_mode),
        .code_out(code_out), .code_valid(code_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    // Offsets are the digits of a single base-DEPTH counter.
    function automatic int off_of(int r);
        int d = 1;
        for (int i = 0; i < r; i++) d = d * DEPTH;
        return (pos / d) % DEPTH;
    endfunction

    function automatic int model_enc(int x);
        int v = x;
        for (int r = 0; r < NUM_ROT; r++) v = tt[r][(v + off_of(r)) % DEPTH];
        return v;
    endfunction

    function automatic int model_dec(int y);
        int v = y;
        for (int r = NUM_ROT - 1; r >= 0; r--) v = (inv_t[r][v] - off_of(r) + DEPTH) % DEPTH;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (code_valid) begin
                if (exp_q.size() == 0) check("unexpected_code_valid", 1, 0);
                else check("code_out", int'(code_out), exp_q.pop_front());
            end
        end
    endtask

    task automatic load_tables(bit pri);
        load     = 1'b1;
        in_valid = pri;
        encrypt  = 1'b1;
        load_rot = '0;
        load_idx = '0;
        code_in  = SYM_W'(tt[0][0]);
        step();
        if (pri) begin
            check("priority_no_valid", int'(code_valid), 0);
            check("priority_state_load", int'(ready), 0);
        end
        in_valid = 1'b0;
        for (int r = 0; r < NUM_ROT; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                load_rot = ROT_W'(r);
                load_idx = SYM_W'(i);
                code_in  = SYM_W'(tt[r][i]);
                step();
            end
        end
        if (NUM_ROT < 2 ** ROT_W) begin
            load_rot = ROT_W'(NUM_ROT);
            load_idx = '0;
            code_in  = 6'h2A;
            step();
        end
        load = 1'b0;
        step();
        check("ready_after_load", int'(ready), 1);
        for (int r = 0; r < NUM_ROT; r++)
            for (int i = 0; i < DEPTH; i++) inv_t[r][tt[r][i]] = i;
        pos = 0;
    endtask

    task automatic send(int sym, bit enc, bit mode, int exp);
        code_in    = SYM_W'(sym);
        in_valid   = 1'b1;
        encrypt    = enc;
        crypt_mode = mode;
        exp_q.push_back(exp);
        step();
        if (mode) pos = (pos + 1) % span;
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        span = 1;
        for (int r = 0; r < NUM_ROT; r++) span = span * DEPTH;
        srstn = 1'b1; load = 1'b0; load_rot = '0; load_idx = '0; code_in = '0;
        in_valid = 1'b0; encrypt = 1'b1; crypt_mode = 1'b0; pos = 0;
        fork
            monitor_loop();
        join_none
        step();
        step();
        check("reset_code_valid", int'(code_valid), 0);
        check("reset_code_out", int'(code_out), 0);
        check("reset_ready", int'(ready), 0);

        srstn = 1'b0; in_valid = 1'b1; code_in = 6'h05;
        repeat (3) begin
            step();
            check("idle_no_output", int'(code_valid), 0);
        end
        in_valid = 1'b0;

        for (int r = 0; r < NUM_ROT; r++)
            for (int i = 0; i < DEPTH; i++) tt[r][i] = i;
        load_tables(1'b0);
        send(8'h05, 1'b1, 1'b0, 8'h05);
        send(8'h3F, 1'b1, 1'b0, 8'h3F);
        send(8'h3F, 1'b1, 1'b0, 8'h3F);
        in_valid = 1'b0;
        #1 srstn = 1'b1;
        #1;
        check("async_reset_code_valid", int'(code_valid), 0);
        check("async_reset_code_out", int'(code_out), 0);
        check("async_reset_ready", int'(ready), 0);
        exp_q.delete();
        pos = 0;
        step();
        srstn = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            step();
            check("post_reset_no_output", int'(code_valid), 0);
        end
        in_valid = 1'b0;

        for (int r = 0; r < NUM_ROT; r++)
            for (int i = 0; i < DEPTH; i++) tt[r][i] = (i + 1) % DEPTH;
        load_tables(1'b0);
        send(0, 1'b1, 1'b1, 8'h02);
        send(0, 1'b1, 1'b1, 8'h03);
        send(0, 1'b1, 1'b1, 8'h04);
        load_tables(1'b1);
        for (int k = 0; k < DEPTH; k++) send(0, 1'b1, 1'b1, model_enc(0));
        send(0, 1'b1, 1'b1, 8'h03);
        quiet();

        for (int r = 0; r < NUM_ROT; r++) begin
            for (int i = 0; i < DEPTH; i++) tt[r][i] = i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(0, i));
                t = tt[r][i]; tt[r][i] = tt[r][j]; tt[r][j] = t;
            end
        end
        load_tables(1'b0);
        for (int k = 0; k < 23; k++) begin
            pt[k] = int'($urandom_range(0, DEPTH - 1));
            ct[k] = model_enc(pt[k]);
            send(pt[k], 1'b1, 1'b1, ct[k]);
        end
        quiet();
        srstn = 1'b1;
        step();
        srstn = 1'b0;
        load_tables(1'b0);
        for (int k = 0; k < 23; k++) send(ct[k], 1'b0, 1'b1, pt[k]);
        quiet();

        for (int k = 0; k < 40; k++) begin
            int sym;
            bit enc, md;
            sym = int'($urandom_range(0, DEPTH - 1));
            enc = bit'($urandom_range(0, 1));
            md  = bit'($urandom_range(0, 1));
            send(sym, enc, md, enc ? model_enc(sym) : model_dec(sym));
        end
        quiet();
        step();
        step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
